mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Data-bus access controller sitting between the execute/memory pipeline register and the memory stage.
- Takes one load/store per instruction and issues it on the dbus.
- Waits for the response, then aligns and extends load data.
- Produces the finish pulse, the fresh data (data2), the held data (data1) and the memory exception consumed by the memory stage.
- Drives a stall to hold the pipeline while a transaction is outstanding.

Parameters:
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  instruction in this stage performs a memory access (dataE.en and load/store ctl)
- is_store  in  1  1 = store, 0 = load
- msize  in  3  msize_t: 0 = byte, 1 = half, 2 = word, 3 = double
- is_unsigned  in  1  zero-extend load result
- addr  in  64  effective address (alu_result)
- wdata  in  64  store data, right-justified
- advance  in  1  pipeline register downstream accepts this instruction
- flush  in  1  squash the current instruction
- dreq  out  dbus_req_t  fields: valid, addr, size, strobe[7:0], data[63:0]
- dresp  in  dbus_resp_t  fields: addr_ok, data_ok, data[63:0]
- finish  out  1  load/store completed this cycle
- data_now  out  64  aligned/extended load data from dresp (memory stage data2)
- data_held  out  64  registered copy of the last completed load (memory stage data1)
- stall  out  1  hold upstream stages
- mem_is_exception  out  1  misaligned access detected
- mem_exception  out  exception_t  code 4 = load misaligned, 6 = store misaligned; tval = addr

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE; dreq.valid = 0; finish = 0; stall = 0; mem_is_exception = 0; data_held = 0.
  - All captured request registers = 0.
- Misaligned rule: addr[2:0] & ((1<<msize)-1) != 0.
- States: IDLE, REQ, DONE, DRAIN.
- IDLE:
  - req_valid && !flush && !misaligned: capture addr, size, strobe and shifted data; next = REQ; stall = 1 this cycle.
  - req_valid && misaligned: mem_is_exception = 1 (combinational); no request; stall = 0; stay IDLE.
- REQ:
  - dreq.valid = 1, with addr/size/strobe/data held stable until data_ok. An addr_ok without data_ok changes nothing.
  - Single-beat response: when dresp.data_ok = 1, finish = 1 that same cycle and data_now = align(dresp.data).
  - On data_ok, data_held <= align(dresp.data) for loads; data_held is unchanged for stores.
  - stall = !dresp.data_ok, so zero bubble after the response.
  - Transition on data_ok: advance ? IDLE : DONE.
  - flush without data_ok: next = DRAIN. A transaction cannot be aborted.
  - flush with data_ok in the same cycle: finish is suppressed; next = IDLE.
- DONE:
  - finish = 0; stall = 0; data_held valid (memory stage selects data1).
  - advance or flush: next = IDLE.
  - Minimum latency: IDLE to finish is 1 cycle if data_ok arrives in the first REQ cycle.
- DRAIN:
  - dreq.valid = 1 until data_ok; stall = 1; finish = 0; data_held unchanged.
  - data_ok: next = IDLE.
- Alignment arithmetic:
  - sh = addr[2:0]; strobe = ((1<<(1<<msize))-1) << sh, truncated to 8 bits.
  - dreq.data = wdata << (8*sh).
  - Load: raw = dresp.data >> (8*sh), then take the low 8/16/32/64 bits. Sign-extend unless is_unsigned. msize = 3 ignores is_unsigned.
- Stores: dreq.data/strobe as above; data_now = 0.
- Back-to-back accesses: a new request is accepted only in IDLE. Accept in the same cycle as REQ→IDLE on data_ok is not allowed; the next request starts the following cycle.

Optional Feature:
- Macro: MEM_ACCESS_PERF_EN.
- Defined:
  - Adds outputs perf_loads, perf_stores and perf_wait_cycles (each PERF_W wide), reset to 0 asynchronously.
  - perf_loads / perf_stores increment on each finish, by access type.
  - perf_wait_cycles increments every cycle that state is REQ or DRAIN.
  - All three wrap modulo 2^PERF_W.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared pipes package: mem_state_t enum, exception code constants EXC_LOAD_MISALIGNED = 4 and EXC_STORE_MISALIGNED = 6.
- Common package (already holds dbus_req_t, dbus_resp_t, msize_t): add functions for strobe generation and load extension.
- Sub-module mem_align (combinational): strobe/wdata shift and load extract/extend, so it can be tested alone.

Test Plan:
- Load byte, addr = 0x1003, msize = 0, signed, dresp.data = 0x0000_0000_8000_0000 with data_ok in the first REQ cycle -> dreq.strobe = 0x08; finish pulses; data_now = 0xFFFF_FFFF_FFFF_FF80.
- Store half, addr = 0x2006, wdata = 0xBEEF, data_ok after 3 cycles -> dreq.strobe = 0xC0, dreq.data = 0xBEEF_0000_0000_0000, dreq stable for 3 cycles, stall high for 3 cycles then low with finish.
- Load word unsigned, addr = 0x4, data_ok while advance = 0 -> DONE; data_held = 0x0000_0000_DEAD_BEEF; finish low in DONE; IDLE after advance.
- Misaligned double load at addr = 0x8004 -> mem_is_exception = 1, code 4, tval = 0x8004; dreq.valid stays 0; stall = 0.
- Flush in the second REQ cycle, data_ok in the fourth -> DRAIN; finish never asserted; data_held unchanged; IDLE in the fifth cycle.
- resetn dropped while in REQ -> dreq.valid = 0 and state = IDLE immediately (asynchronous), with no clock edge required.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_pkg
// Purpose : Shared types, constants and helper functions for the data-bus
//           access controller: dbus request/response structs, access size
//           encoding, exception record, controller state encoding, and the
//           byte-lane / load-extension arithmetic used by mem_align.
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Access size: number of bytes is 1 << size.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [3:0]  code;
        logic [63:0] tval;
    } exception_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } mem_state_t;

    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(msize_t size);
        logic [2:0] mask;
        case (size)
            MSIZE1:  mask = 3'b000;
            MSIZE2:  mask = 3'b001;
            MSIZE4:  mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(logic [2:0] sh, msize_t size);
        return |(sh & align_mask(size));
    endfunction

    // Byte-lane enables for an access of 'size' starting at byte lane 'sh'.
    function automatic logic [7:0] gen_strobe(msize_t size, logic [2:0] sh);
        logic [7:0] base;
        case (size)
            MSIZE1:  base = 8'h01;
            MSIZE2:  base = 8'h03;
            MSIZE4:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << sh;
    endfunction

    // Move right-justified store data onto its byte lanes.
    function automatic logic [63:0] store_shift(logic [63:0] wdata, logic [2:0] sh);
        return wdata << {sh, 3'b000};
    endfunction

    // Bring the addressed bytes down to bit 0, then zero/sign extend.
    // Double-word loads have nothing to extend, so is_unsigned is moot there.
    function automatic logic [63:0] load_extend(logic [63:0] raw, msize_t size,
                                                logic [2:0] sh, logic is_unsigned);
        logic [63:0] s;
        logic [63:0] res;
        s = raw >> {sh, 3'b000};
        case (size)
            MSIZE1:  res = is_unsigned ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            MSIZE2:  res = is_unsigned ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            MSIZE4:  res = is_unsigned ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: res = s;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_if
// Purpose : Data-bus connection between the access controller and memory.
//           dreq  - request (valid, addr, size, strobe, data)
//           dresp - response (addr_ok, data_ok, data)
//           modport master : controller side (drives dreq)
//           modport slave  : memory side (drives dresp)
// Revision: 1.0 - initial release
// ============================================================================
interface mem_access_if;
    import mem_access_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input  dresp);
    modport slave  (input  dreq, output dresp);

endinterface
`default_nettype wire

// File: rtl/mem_access_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_align
// Purpose : Purely combinational lane steering for the access controller.
//           Store path: byte strobe and lane-shifted write data.
//           Load path : extract addressed bytes from the response and extend.
// Ports   : i_st_sh, i_st_size, i_st_wdata -> o_st_strobe, o_st_data
//           i_ld_sh, i_ld_size, i_ld_unsigned, i_ld_raw -> o_ld_data
// Revision: 1.0 - initial release
// ============================================================================
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  i_st_sh,
    input  msize_t      i_st_size,
    input  logic [63:0] i_st_wdata,
    output logic [7:0]  o_st_strobe,
    output logic [63:0] o_st_data,

    input  logic [2:0]  i_ld_sh,
    input  msize_t      i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [63:0] i_ld_raw,
    output logic [63:0] o_ld_data
);

    assign o_st_strobe = gen_strobe(i_st_size, i_st_sh);
    assign o_st_data   = store_shift(i_st_wdata, i_st_sh);
    assign o_ld_data   = load_extend(i_ld_raw, i_ld_size, i_ld_sh, i_ld_unsigned);

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module  : mem_access
// Purpose : Data-bus access controller between the execute/memory pipeline
//           register and the memory stage. Issues one load/store per
//           instruction, waits for the single-beat response, aligns/extends
//           load data and stalls the pipeline while a transaction is open.
// Ports   : clk, resetn (async, active low)
//           req_valid, is_store, msize, is_unsigned, addr, wdata - access
//           advance, flush  - downstream accept / squash
//           dbus            - mem_access_if.master (dreq / dresp)
//           finish, data_now, data_held, stall - memory stage interface
//           mem_is_exception, mem_exception     - misaligned access report
// Option  : MEM_ACCESS_PERF_EN adds parameter PERF_W and outputs perf_loads,
//           perf_stores, perf_wait_cycles (wrapping counters).
// Revision: 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
`ifdef MEM_ACCESS_PERF_EN
#(
    parameter int PERF_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              resetn,

    input  logic              req_valid,
    input  logic              is_store,
    input  msize_t            msize,
    input  logic              is_unsigned,
    input  logic [63:0]       addr,
    input  logic [63:0]       wdata,
    input  logic              advance,
    input  logic              flush,

    mem_access_if.master      dbus,

    output logic              finish,
    output logic [63:0]       data_now,
    output logic [63:0]       data_held,
    output logic              stall,
    output logic              mem_is_exception,
    output exception_t        mem_exception
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_loads,
    output logic [PERF_W-1:0] perf_stores,
    output logic [PERF_W-1:0] perf_wait_cycles
`endif
);

    mem_state_t  r_state;
    mem_state_t  w_next;

    // Captured request, held stable on dreq until data_ok.
    logic [63:0] r_addr;
    msize_t      r_size;
    logic [7:0]  r_strobe;
    logic [63:0] r_wdata;
    logic        r_is_store;
    logic        r_unsigned;
    logic [63:0] r_data_held;

    logic        w_misaligned;
    logic        w_capture;
    logic        w_dvalid;
    logic        w_finish;
    logic        w_stall;
    logic        w_exc;
    logic [7:0]  w_st_strobe;
    logic [63:0] w_st_data;
    logic [63:0] w_ld_data;
    logic [63:0] w_data_now;

    mem_align u_align (
        .i_st_sh       (addr[2:0]),
        .i_st_size     (msize),
        .i_st_wdata    (wdata),
        .o_st_strobe   (w_st_strobe),
        .o_st_data     (w_st_data),
        .i_ld_sh       (r_addr[2:0]),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_ld_raw      (dbus.dresp.data),
        .o_ld_data     (w_ld_data)
    );

    assign w_misaligned = is_misaligned(addr[2:0], msize);

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_dvalid  = 1'b0;
        w_finish  = 1'b0;
        w_stall   = 1'b0;
        w_exc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misaligned) begin
                        // Reported to the memory stage; nothing goes on the bus.
                        w_exc = 1'b1;
                    end else if (!flush) begin
                        w_capture = 1'b1;
                        w_stall   = 1'b1;
                        w_next    = REQ;
                    end
                end
            end
            REQ: begin
                w_dvalid = 1'b1;
                if (dbus.dresp.data_ok) begin
                    // A flush landing with the response squashes the result.
                    w_finish = !flush;
                    w_next   = (advance || flush) ? IDLE : DONE;
                end else begin
                    w_stall = 1'b1;
                    // The bus transaction cannot be aborted, so wait it out.
                    if (flush) begin
                        w_next = DRAIN;
                    end
                end
            end
            DONE: begin
                // Result sits in data_held until the pipeline moves on.
                if (advance || flush) begin
                    w_next = IDLE;
                end
            end
            DRAIN: begin
                w_dvalid = 1'b1;
                w_stall  = 1'b1;
                if (dbus.dresp.data_ok) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_data_now = r_is_store ? 64'd0 : w_ld_data;

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_addr      <= 64'd0;
            r_size      <= MSIZE1;
            r_strobe    <= 8'd0;
            r_wdata     <= 64'd0;
            r_is_store  <= 1'b0;
            r_unsigned  <= 1'b0;
            r_data_held <= 64'd0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr     <= addr;
                r_size     <= msize;
                r_strobe   <= w_st_strobe;
                r_wdata    <= w_st_data;
                r_is_store <= is_store;
                r_unsigned <= is_unsigned;
            end
            if (w_finish && !r_is_store) begin
                r_data_held <= w_ld_data;
            end
        end
    end

    assign dbus.dreq = '{valid:  w_dvalid,
                         addr:   r_addr,
                         size:   r_size,
                         strobe: r_strobe,
                         data:   r_wdata};

    assign finish           = w_finish;
    assign data_now         = w_data_now;
    assign data_held        = r_data_held;
    assign stall            = w_stall;
    assign mem_is_exception = w_exc;
    assign mem_exception    = w_exc ? '{code: (is_store ? EXC_STORE_MISALIGNED
                                                        : EXC_LOAD_MISALIGNED),
                                        tval: addr}
                                    : '{code: 4'd0, tval: 64'd0};

`ifdef MEM_ACCESS_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^PERF_W)
    // ------------------------------------------------------------------
    logic [PERF_W-1:0] r_perf_loads;
    logic [PERF_W-1:0] r_perf_stores;
    logic [PERF_W-1:0] r_perf_wait;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_loads  <= '0;
            r_perf_stores <= '0;
            r_perf_wait   <= '0;
        end else begin
            if (w_finish && !r_is_store) begin
                r_perf_loads <= r_perf_loads + PERF_W'(1);
            end
            if (w_finish && r_is_store) begin
                r_perf_stores <= r_perf_stores + PERF_W'(1);
            end
            if (r_state == REQ || r_state == DRAIN) begin
                r_perf_wait <= r_perf_wait + PERF_W'(1);
            end
        end
    end

    assign perf_loads       = r_perf_loads;
    assign perf_stores      = r_perf_stores;
    assign perf_wait_cycles = r_perf_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access
// Purpose : Directed, self-checking bench for mem_access. Stimulus pushes the
//           expected finish/exception record into a queue; a negedge monitor
//           pops and compares whenever the DUT raises finish or an exception.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        is_store;
    msize_t      msize;
    logic        is_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        advance;
    logic        flush;
    logic        finish;
    logic [63:0] data_now;
    logic [63:0] data_held;
    logic        stall;
    logic        mem_is_exception;
    exception_t  mem_exception;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_wait_cycles;
`endif

    mem_access_if bif ();

    mem_access dut (
        .clk              (clk),
        .resetn           (resetn),
        .req_valid        (req_valid),
        .is_store         (is_store),
        .msize            (msize),
        .is_unsigned      (is_unsigned),
        .addr             (addr),
        .wdata            (wdata),
        .advance          (advance),
        .flush            (flush),
        .dbus             (bif),
        .finish           (finish),
        .data_now         (data_now),
        .data_held        (data_held),
        .stall            (stall),
        .mem_is_exception (mem_is_exception),
        .mem_exception    (mem_exception)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .perf_loads       (perf_loads),
        .perf_stores      (perf_stores),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_exc;
        logic [63:0] data_now;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [3:0]  code;
        logic [63:0] tval;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void push_acc(logic [63:0] dn, logic [7:0] sb, logic [63:0] wd);
        exp_t e;
        e.is_exc = 1'b0; e.data_now = dn; e.strobe = sb; e.wdata = wd;
        e.code = 4'd0;   e.tval = 64'd0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_exc(logic [3:0] code, logic [63:0] tval);
        exp_t e;
        e.is_exc = 1'b1; e.data_now = 64'd0; e.strobe = 8'd0; e.wdata = 64'd0;
        e.code = code;   e.tval = tval;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (resetn && (finish || mem_is_exception)) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_event", {62'd0, finish, mem_is_exception}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_finish", finish, !mon_e.is_exc);
                chk("sb_exception", mem_is_exception, mon_e.is_exc);
                if (mon_e.is_exc) begin
                    chk("sb_exc_code", mem_exception.code, mon_e.code);
                    chk("sb_exc_tval", mem_exception.tval, mon_e.tval);
                    chk("sb_exc_no_req", bif.dreq.valid, 1'b0);
                    chk("sb_exc_no_stall", stall, 1'b0);
                end else begin
                    chk("sb_data_now", data_now, mon_e.data_now);
                    chk("sb_strobe", bif.dreq.strobe, mon_e.strobe);
                    chk("sb_wdata", bif.dreq.data, mon_e.wdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; is_store = 1'b0; msize = MSIZE1; is_unsigned = 1'b0;
        addr = 64'd0; wdata = 64'd0; advance = 1'b1; flush = 1'b0;
        bif.dresp = '0;
    endtask

    task automatic issue(logic st, msize_t sz, logic uns, logic [63:0] a, logic [63:0] wd);
        req_valid = 1'b1; is_store = st; msize = sz; is_unsigned = uns;
        addr = a; wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_dvalid", bif.dreq.valid, 1'b0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_exc", mem_is_exception, 1'b0);
        chk("rst_held", data_held, 64'd0);
        #1 resetn = 1'b1;
        step();

        // ---- Load byte, signed, response in first REQ cycle ----
        issue(1'b0, MSIZE1, 1'b0, 64'h1003, 64'd0);
        push_acc(64'hFFFF_FFFF_FFFF_FF80, 8'h08, 64'd0);
        @(negedge clk);
        chk("lb_accept_stall", stall, 1'b1);
        chk("lb_idle_novalid", bif.dreq.valid, 1'b0);
        step();
        req_valid = 1'b0;
        bif.dresp.data_ok = 1'b1;
        bif.dresp.data    = 64'h0000_0000_8000_0000;
        @(negedge clk);
        chk("lb_req_valid", bif.dreq.valid, 1'b1);
        chk("lb_req_addr", bif.dreq.addr, 64'h1003);
        chk("lb_stall_low", stall, 1'b0);
        step();
        bif.dresp = '0;
        @(negedge clk);
        chk("lb_held", data_held, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_back_idle", bif.dreq.valid, 1'b0);
        step();

        // ---- Store half, response after 3 wait cycles ----
        issue(1'b1, MSIZE2, 1'b0, 64'h2006, 64'hBEEF);
        push_acc(64'd0, 8'hC0, 64'hBEEF_0000_0000_0000);
        @(negedge clk);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bif.dresp.addr_ok = (i == 0);
            @(negedge clk);
            chk("sh_wait_stall", stall, 1'b1);
            chk("sh_wait_valid", bif.dreq.valid, 1'b1);
            chk("sh_wait_strobe", bif.dreq.strobe, 8'hC0);
            chk("sh_wait_data", bif.dreq.data, 64'hBEEF_0000_0000_0000);
            chk("sh_wait_finish", finish, 1'b0);
            step();
        end
        bif.dresp.addr_ok = 1'b0;
        bif.dresp.data_ok = 1'b1;
        bif.dresp.data    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("sh_done_stall", stall, 1'b0);
        step();
        bif.dresp = '0;
        @(negedge clk);
        chk("sh_held_kept", data_held, 64'hFFFF_FFFF_FFFF_FF80);
        step();

        // ---- Load word unsigned, no advance -> DONE ----
        issue(1'b0, MSIZE4, 1'b1, 64'h4, 64'd0);
        push_acc(64'h0000_0000_DEAD_BEEF, 8'hF0, 64'd0);
        @(negedge clk);
        step();
        req_valid = 1'b0;
        advance   = 1'b0;
        bif.dresp.data_ok = 1'b1;
        bif.dresp.data    = 64'hDEAD_BEEF_0000_0000;
        @(negedge clk);
        step();
        bif.dresp = '0;
        @(negedge clk);
        chk("lw_done_finish", finish, 1'b0);
        chk("lw_done_stall", stall, 1'b0);
        chk("lw_done_valid", bif.dreq.valid, 1'b0);
        chk("lw_done_held", data_held, 64'h0000_0000_DEAD_BEEF);
        step();
        advance = 1'b1;
        @(negedge clk);
        step();

        // ---- Misaligned accesses (must be back in IDLE to report) ----
        issue(1'b0, MSIZE8, 1'b0, 64'h8004, 64'd0);
        push_exc(EXC_LOAD_MISALIGNED, 64'h8004);
        @(negedge clk);
        step();
        issue(1'b1, MSIZE2, 1'b0, 64'h2001, 64'h1234);
        push_exc(EXC_STORE_MISALIGNED, 64'h2001);
        @(negedge clk);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("mis_stay_idle", bif.dreq.valid, 1'b0);
        step();

        // ---- Flush in 2nd REQ cycle, response in 4th -> DRAIN ----
        issue(1'b0, MSIZE1, 1'b1, 64'h0, 64'd0);
        @(negedge clk);
        step();                               // cycle 1: REQ
        req_valid = 1'b0;
        @(negedge clk);
        chk("fl_c1_stall", stall, 1'b1);
        step();                               // cycle 2: REQ + flush
        flush = 1'b1;
        @(negedge clk);
        chk("fl_c2_finish", finish, 1'b0);
        step();                               // cycle 3: DRAIN
        flush = 1'b0;
        @(negedge clk);
        chk("fl_c3_valid", bif.dreq.valid, 1'b1);
        chk("fl_c3_stall", stall, 1'b1);
        step();                               // cycle 4: DRAIN + data_ok
        bif.dresp.data_ok = 1'b1;
        bif.dresp.data    = 64'h55;
        @(negedge clk);
        chk("fl_c4_finish", finish, 1'b0);
        chk("fl_c4_stall", stall, 1'b1);
        step();                               // cycle 5: IDLE
        bif.dresp = '0;
        @(negedge clk);
        chk("fl_c5_valid", bif.dreq.valid, 1'b0);
        chk("fl_c5_stall", stall, 1'b0);
        chk("fl_held_kept", data_held, 64'h0000_0000_DEAD_BEEF);
        step();

        // ---- Back-to-back: double (is_unsigned ignored) then signed half ----
        issue(1'b0, MSIZE8, 1'b1, 64'h10, 64'd0);
        push_acc(64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0);
        @(negedge clk);
        step();
        bif.dresp.data_ok = 1'b1;
        bif.dresp.data    = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        step();
        bif.dresp = '0;
        issue(1'b0, MSIZE2, 1'b0, 64'h12, 64'd0);
        push_acc(64'hFFFF_FFFF_FFFF_8001, 8'h0C, 64'd0);
        @(negedge clk);
        chk("b2b_gap_valid", bif.dreq.valid, 1'b0);
        chk("b2b_accept_stall", stall, 1'b1);
        step();
        req_valid = 1'b0;
        bif.dresp.data_ok = 1'b1;
        bif.dresp.data    = 64'h0000_0000_8001_0000;
        @(negedge clk);
        chk("b2b_req_valid", bif.dreq.valid, 1'b1);
        step();
        bif.dresp = '0;
        @(negedge clk);
        step();

        // ---- Asynchronous reset while in REQ ----
        issue(1'b0, MSIZE4, 1'b0, 64'h20, 64'd0);
        @(negedge clk);
        step();
        req_valid = 1'b0;
        #1;
        chk("ar_in_req", bif.dreq.valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("ar_valid", bif.dreq.valid, 1'b0);
        chk("ar_stall", stall, 1'b0);
        chk("ar_finish", finish, 1'b0);
        chk("ar_held", data_held, 64'd0);
        @(negedge clk);
        #1 resetn = 1'b1;
        step();
        @(negedge clk);
        chk("ar_after_valid", bif.dreq.valid, 1'b0);
        step();

        chk("sb_drained", exp_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
